// File: rtl/power_bus_pkg.sv
// rtl/power_bus_pkg.sv - shared state codes and helpers for the power bus manager
package power_bus_pkg;

  // Width of the power bus FSM state register
  localparam int PB_SW = 3;

  localparam logic [PB_SW-1:0] PB_OFF       = 3'd0;
  localparam logic [PB_SW-1:0] PB_CHARGE    = 3'd1;
  localparam logic [PB_SW-1:0] PB_DISCHARGE = 3'd2;
  localparam logic [PB_SW-1:0] PB_SHED      = 3'd3;
  localparam logic [PB_SW-1:0] PB_DEPLETED  = 3'd4;

  // Low-charge alert is raised whenever loads are being shed or the battery is empty
  function automatic logic pb_is_low(input logic [PB_SW-1:0] s);
    return (s == PB_SHED) || (s == PB_DEPLETED);
  endfunction

endpackage

// File: rtl/power_bus_dff.sv
// rtl/power_bus_dff.sv - common resettable D flip-flop
module power_bus_dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register with synchronous reset to RST_VAL
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/power_bus_load_arbiter.sv
// rtl/power_bus_load_arbiter.sv - grant mask from next state and draw of currently running loads
module load_arbiter
  import power_bus_pkg::*;
#(
  parameter int NLOAD = 3,
  parameter int DW    = 8,
  parameter int KEEP  = 1,
  parameter int SW    = DW + $clog2(NLOAD) + 1
) (
  input  logic [PB_SW-1:0]    state_nx,
  input  logic [NLOAD-1:0]    load_req,
  input  logic [NLOAD-1:0]    load_grant,
  input  logic [NLOAD*DW-1:0] draw,
  output logic [NLOAD-1:0]    grant_nx,
  output logic [SW-1:0]       used
);

  logic [NLOAD-1:0] keep_mask;

  // Only the highest-priority loads (index below KEEP) survive shedding
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < NLOAD; i++) keep_mask[i] = (i < KEEP);
  end

  // Grants follow the state the bus is about to enter
  always_comb begin
    grant_nx = '0;
    case (state_nx)
      PB_CHARGE, PB_DISCHARGE: grant_nx = load_req;
      PB_SHED:                 grant_nx = load_req & keep_mask;
      default:                 grant_nx = '0;
    endcase
  end

  // A load only consumes power while it both holds a grant and still requests
  always_comb begin
    used = '0;
    for (int i = 0; i < NLOAD; i++) begin
      if (load_grant[i] && load_req[i]) used = used + SW'(draw[i*DW +: DW]);
    end
  end

endmodule

// File: rtl/power_bus.sv
// rtl/power_bus.sv - battery integration, load granting and low-charge shedding
module power_bus
  import power_bus_pkg::*;
#(
  parameter int NLOAD       = 3,
  parameter int GW          = 8,
  parameter int DW          = 8,
  parameter int CW          = 12,
  parameter int CAP         = 4000,
  parameter int INIT_CHARGE = 2000,
  parameter int LOW_TH      = 1000,
  parameter int RECOVER_TH  = 1500,
  parameter int KEEP        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  input  logic [GW-1:0]       gen,
  input  logic [NLOAD-1:0]    load_req,
  input  logic [NLOAD*DW-1:0] draw,
  output logic [NLOAD-1:0]    load_grant,
  output logic [CW-1:0]       charge,
  output logic [PB_SW-1:0]    state,
  output logic                alert_low,
  output logic [15:0]         shed_cnt
);

  localparam int SW = DW + $clog2(NLOAD) + 1;
  localparam int IW = CW + 2;

  localparam logic signed [IW-1:0] CAP_S   = IW'(CAP);
  localparam logic [CW-1:0]        LOW_C   = CW'(LOW_TH);
  localparam logic [CW-1:0]        REC_C   = CW'(RECOVER_TH);
  localparam logic [CW-1:0]        INIT_C  = CW'(INIT_CHARGE);

  logic [SW-1:0]          used;
  logic signed [IW-1:0]   sum_s;
  logic [CW-1:0]          charge_nx;
  logic                   net_pos;
  logic                   integrate;
  logic [PB_SW-1:0]       state_nx;
  logic [NLOAD-1:0]       grant_nx;

  load_arbiter #(
    .NLOAD (NLOAD),
    .DW    (DW),
    .KEEP  (KEEP),
    .SW    (SW)
  ) u_arb (
    .state_nx   (state_nx),
    .load_req   (load_req),
    .load_grant (load_grant),
    .draw       (draw),
    .grant_nx   (grant_nx),
    .used       (used)
  );

  // Candidate charge after this tick's generation and consumption, clamped to [0, CAP]
  always_comb begin
    sum_s   = $signed({2'b00, charge}) + $signed(IW'(gen)) - $signed(IW'(used));
    net_pos = (IW'(gen) >= IW'(used));
    if (sum_s[IW-1])        charge_nx = '0;
    else if (sum_s > CAP_S) charge_nx = CAP_S[CW-1:0];
    else                    charge_nx = sum_s[CW-1:0];
  end

  // FSM: charge thresholds with hysteresis; losing the enable overrides every other exit
  always_comb begin
    state_nx  = PB_OFF;
    integrate = 1'b0;
    case (state)
      PB_OFF: state_nx = PB_CHARGE;
      PB_CHARGE, PB_DISCHARGE: begin
        integrate = 1'b1;
        if (charge_nx == '0)      state_nx = PB_DEPLETED;
        else if (charge_nx < LOW_C) state_nx = PB_SHED;
        else                      state_nx = net_pos ? PB_CHARGE : PB_DISCHARGE;
      end
      PB_SHED: begin
        integrate = 1'b1;
        if (charge_nx == '0)        state_nx = PB_DEPLETED;
        else if (charge_nx >= REC_C) state_nx = net_pos ? PB_CHARGE : PB_DISCHARGE;
        else                        state_nx = PB_SHED;
      end
      PB_DEPLETED: begin
        integrate = 1'b1;
        state_nx  = (charge_nx >= LOW_C) ? PB_SHED : PB_DEPLETED;
      end
      default: state_nx = PB_OFF;
    endcase
    if (!in) state_nx = PB_OFF;
  end

  power_bus_dff #(
    .W       (PB_SW),
    .RST_VAL (PB_OFF)
  ) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_nx),
    .q   (state)
  );

  // Charge, grants, alert and shed counter all register from the next-state decision
  always_ff @(posedge clk) begin
    if (rst) begin
      charge     <= INIT_C;
      load_grant <= '0;
      alert_low  <= 1'b0;
      shed_cnt   <= '0;
    end else begin
      if (integrate) charge <= charge_nx;
      load_grant <= grant_nx;
      alert_low  <= pb_is_low(state_nx);
      if (|(load_req & ~grant_nx) && (state_nx != PB_OFF) && (shed_cnt != 16'hFFFF))
        shed_cnt <= shed_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_power_bus.sv
// tb/tb_power_bus.sv - scoreboard bench for power_bus
module tb_power_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in = 1'b0;
  logic [7:0]  gen = '0;
  logic [2:0]  load_req = '0;
  logic [23:0] draw = '0;
  logic [2:0]  load_grant;
  logic [11:0] charge;
  logic [2:0]  state;
  logic        alert_low;
  logic [15:0] shed_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ch;
    logic [2:0]  g;
    logic        al;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int         m_st = 0;
  int         m_ch = 2000;
  logic [2:0] m_g = '0;
  logic       m_al = 1'b0;
  int         m_sc = 0;

  power_bus dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .gen        (gen),
    .load_req   (load_req),
    .draw       (draw),
    .load_grant (load_grant),
    .charge     (charge),
    .state      (state),
    .alert_low  (alert_low),
    .shed_cnt   (shed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input logic r, input logic en, input int g, input logic [2:0] req,
                      input int d0, input int d1, input int d2);
    exp_t e;
    int used;
    int c;
    int ns;
    logic np;
    logic [2:0] gn;
    @(negedge clk);
    rst = r; in = en; gen = 8'(g); load_req = req;
    draw = {8'(d2), 8'(d1), 8'(d0)};
    if (r) begin
      m_st = 0; m_ch = 2000; m_g = '0; m_al = 1'b0; m_sc = 0;
    end else begin
      used = 0;
      if (m_g[0] && req[0]) used += d0;
      if (m_g[1] && req[1]) used += d1;
      if (m_g[2] && req[2]) used += d2;
      c = m_ch + g - used;
      if (c < 0) c = 0;
      if (c > 4000) c = 4000;
      np = (g >= used);
      case (m_st)
        0: begin ns = 1; c = m_ch; end
        1, 2: ns = (c == 0) ? 4 : (c < 1000) ? 3 : (np ? 1 : 2);
        3: ns = (c == 0) ? 4 : (c >= 1500) ? (np ? 1 : 2) : 3;
        4: ns = (c >= 1000) ? 3 : 4;
        default: begin ns = 0; c = m_ch; end
      endcase
      if (!en) ns = 0;
      gn = (ns == 1 || ns == 2) ? req : (ns == 3) ? (req & 3'b001) : 3'b000;
      if (((req & ~gn) != 3'b000) && ns != 0 && m_sc != 65535) m_sc++;
      m_st = ns; m_ch = c; m_g = gn; m_al = (ns == 3 || ns == 4);
    end
    e.st = 3'(m_st); e.ch = 12'(m_ch); e.g = m_g; e.al = m_al; e.sc = 16'(m_sc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state",     32'(state),      32'(e.st));
    chk("charge",    32'(charge),     32'(e.ch));
    chk("grant",     32'(load_grant), 32'(e.g));
    chk("alert_low", 32'(alert_low),  32'(e.al));
    chk("shed_cnt",  32'(shed_cnt),   32'(e.sc));
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 3'b000, 0, 0, 0);
    chk("rst_charge", 32'(charge), 32'd2000);
    chk("rst_state",  32'(state),  32'd0);

    // 1: OFF -> CHARGE, then integrate +10 five times
    step(0, 1, 10, 3'b000, 0, 0, 0);
    repeat (5) step(0, 1, 10, 3'b000, 0, 0, 0);
    chk("s1_charge", 32'(charge), 32'd2050);
    chk("s1_state",  32'(state),  32'd1);

    // 2: heavy draw, discharge into SHED
    repeat (5) step(0, 1, 0, 3'b111, 100, 100, 100);
    chk("s2_charge", 32'(charge),     32'd850);
    chk("s2_state",  32'(state),      32'd3);
    chk("s2_grant",  32'(load_grant), 32'd1);
    chk("s2_alert",  32'(alert_low),  32'd1);

    // 3: climb inside SHED to 1490, then cross RECOVER_TH exactly into CHARGE
    repeat (2) step(0, 1, 255, 3'b111, 0, 100, 100);
    step(0, 1, 130, 3'b111, 0, 100, 100);
    chk("s3_pre", 32'(charge), 32'd1490);
    step(0, 1, 50, 3'b111, 30, 100, 100);
    chk("s3_charge", 32'(charge),     32'd1510);
    chk("s3_state",  32'(state),      32'd1);
    chk("s3_grant",  32'(load_grant), 32'd7);
    chk("s3_alert",  32'(alert_low),  32'd0);

    // 4: drain to 50, clamp at 0 into DEPLETED, recharge to exactly LOW_TH
    step(0, 1, 0, 3'b111, 255, 255, 255);
    repeat (2) step(0, 1, 0, 3'b111, 255, 255, 255);
    step(0, 1, 0, 3'b111, 185, 255, 255);
    chk("s4_pre", 32'(charge), 32'd50);
    step(0, 1, 0, 3'b111, 100, 255, 255);
    chk("s4_charge0", 32'(charge),     32'd0);
    chk("s4_state4",  32'(state),      32'd4);
    chk("s4_grant0",  32'(load_grant), 32'd0);
    repeat (4) step(0, 1, 250, 3'b111, 100, 255, 255);
    chk("s4_charge", 32'(charge), 32'd1000);
    chk("s4_state3", 32'(state),  32'd3);

    // 5: charge up to CAP and stay clamped
    repeat (2) step(0, 1, 255, 3'b000, 0, 0, 0);
    repeat (9) step(0, 1, 255, 3'b000, 0, 0, 0);
    step(0, 1, 185, 3'b000, 0, 0, 0);
    chk("s5_pre", 32'(charge), 32'd3990);
    repeat (2) step(0, 1, 255, 3'b000, 0, 0, 0);
    chk("s5_cap", 32'(charge), 32'd4000);

    // LOW_TH exactly from DISCHARGE does not shed; one more step does
    repeat (13) step(0, 1, 0, 3'b001, 250, 0, 0);
    chk("low_th_charge", 32'(charge), 32'd1000);
    chk("low_th_state",  32'(state),  32'd2);
    step(0, 1, 0, 3'b001, 250, 0, 0);
    chk("shed_again", 32'(state), 32'd3);

    // 6: drop enable in SHED, charge frozen while OFF
    step(0, 0, 0, 3'b000, 0, 0, 0);
    chk("s6_off",   32'(state),      32'd0);
    chk("s6_grant", 32'(load_grant), 32'd0);
    step(0, 0, 100, 3'b001, 250, 0, 0);
    chk("s6_frozen", 32'(charge), 32'd750);
    step(0, 1, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 3'b111, 0, 0, 0);
    chk("s6_shed", 32'(state), 32'd3);
    step(1, 1, 0, 3'b111, 0, 0, 0);
    chk("s6_rst_charge", 32'(charge),   32'd2000);
    chk("s6_rst_shed",   32'(shed_cnt), 32'd0);

    // Depletion and enable loss on the same cycle: OFF wins
    step(0, 1, 0, 3'b001, 255, 0, 0);
    repeat (7) step(0, 1, 0, 3'b001, 255, 0, 0);
    chk("dep_pre", 32'(charge), 32'd215);
    step(0, 0, 0, 3'b001, 255, 0, 0);
    chk("dep_off", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
